// File: rtl/kernel_job_dispatcher.sv
// Kernel job dispatcher: queues host descriptors, launches one kernel job at a
// time on the adaptor, and forwards each job's result words with a sequence tag.
module kernel_job_dispatcher #(
  parameter int DSC_WIDTH      = 1024,
  parameter int READREG_NUMBER = 1,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dsc_valid,
  output logic                            dsc_ready,
  input  logic [DSC_WIDTH-1:0]            dsc_data,
  output logic                            kernel_start,
  input  logic                            kernel_ready,
  output logic [DSC_WIDTH-1:0]            kernel_data,
  input  logic                            complete_ready,
  output logic                            complete_accept,
  input  logic [READREG_NUMBER*32-1:0]    complete_data,
  output logic                            cmpl_valid,
  input  logic                            cmpl_ready,
  output logic [READREG_NUMBER*32-1:0]    cmpl_data,
  output logic [7:0]                      cmpl_tag,
  output logic [$clog2(QUEUE_DEPTH):0]    queue_level,
  output logic                            busy
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = READREG_NUMBER * 32;
  localparam logic [LW-1:0] DEPTH_L = LW'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [DSC_WIDTH-1:0]   r_mem [QUEUE_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]          r_level, w_level_nxt;
  logic                   r_dsc_ready;
  logic                   r_kernel_start;
  logic [DSC_WIDTH-1:0]   r_kernel_data;
  logic                   r_complete_accept;
  logic                   r_cmpl_valid, w_cmpl_valid_nxt;
  logic [RW-1:0]          r_cmpl_data;
  logic [7:0]             r_cmpl_tag;
  logic [7:0]             r_tag_cnt, r_job_tag;
  logic                   r_busy;
  logic                   w_push, w_pop, w_capture;

  assign w_push    = dsc_valid & r_dsc_ready;
  assign w_pop     = (r_state == S_IDLE) & (r_level != {LW{1'b0}}) & kernel_ready;
  // Capture only while accept is up, which already implies an empty result slot
  assign w_capture = (r_state == S_DRAIN) & complete_ready & r_complete_accept;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_cmpl_valid_nxt = r_cmpl_valid;
    if (w_capture) begin
      w_cmpl_valid_nxt = 1'b1;
    end else if (r_cmpl_valid && cmpl_ready) begin
      w_cmpl_valid_nxt = 1'b0;
    end else begin
      w_cmpl_valid_nxt = r_cmpl_valid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_pop ? S_LAUNCH : S_IDLE;
      S_LAUNCH: w_state_nxt = S_RUN;
      S_RUN:    w_state_nxt = complete_ready ? S_DRAIN : S_RUN;
      S_DRAIN:  w_state_nxt = w_capture ? S_HOLD : S_DRAIN;
      // Wait for the adaptor to drop complete_ready so one result is never taken twice
      S_HOLD:   w_state_nxt = complete_ready ? S_HOLD : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_wr_ptr          <= {AW{1'b0}};
      r_rd_ptr          <= {AW{1'b0}};
      r_level           <= {LW{1'b0}};
      r_dsc_ready       <= 1'b1;
      r_kernel_start    <= 1'b0;
      r_complete_accept <= 1'b0;
      r_cmpl_valid      <= 1'b0;
      r_tag_cnt         <= 8'd0;
      r_job_tag         <= 8'd0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_level           <= w_level_nxt;
      r_dsc_ready       <= (w_level_nxt < DEPTH_L);
      r_kernel_start    <= w_pop;
      r_complete_accept <= (w_state_nxt == S_DRAIN) & ~w_cmpl_valid_nxt;
      r_cmpl_valid      <= w_cmpl_valid_nxt;
      r_busy            <= (w_state_nxt != S_IDLE);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_job_tag <= r_tag_cnt;
        r_tag_cnt <= r_tag_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= dsc_data;
    end
  end

  // kernel_data only reloads on a pop, so it holds the job until the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kernel_data <= {DSC_WIDTH{1'b0}};
      r_cmpl_data   <= {RW{1'b0}};
      r_cmpl_tag    <= 8'd0;
    end else begin
      if (w_pop) begin
        r_kernel_data <= r_mem[r_rd_ptr];
      end
      if (w_capture) begin
        r_cmpl_data <= complete_data;
        r_cmpl_tag  <= r_job_tag;
      end
    end
  end

  assign dsc_ready       = r_dsc_ready;
  assign kernel_start    = r_kernel_start;
  assign kernel_data     = r_kernel_data;
  assign complete_accept = r_complete_accept;
  assign cmpl_valid      = r_cmpl_valid;
  assign cmpl_data       = r_cmpl_data;
  assign cmpl_tag        = r_cmpl_tag;
  assign queue_level     = r_level;
  assign busy            = r_busy;

endmodule

// File: tb/tb_kernel_job_dispatcher.sv
// Directed bench for kernel_job_dispatcher: a per-cycle vector table for the
// basic flow and queue-full case, then hand-written multi-cycle sequences.
module tb_kernel_job_dispatcher;

  localparam int DW = 1024;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          dsc_valid;
  logic          dsc_ready;
  logic [DW-1:0] dsc_data;
  logic          kernel_start;
  logic          kernel_ready;
  logic [DW-1:0] kernel_data;
  logic          complete_ready;
  logic          complete_accept;
  logic [RW-1:0] complete_data;
  logic          cmpl_valid;
  logic          cmpl_ready;
  logic [RW-1:0] cmpl_data;
  logic [7:0]    cmpl_tag;
  logic [2:0]    queue_level;
  logic          busy;

  int errors = 0;
  int checks = 0;

  kernel_job_dispatcher #(.DSC_WIDTH(DW), .READREG_NUMBER(1), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .dsc_valid(dsc_valid), .dsc_ready(dsc_ready), .dsc_data(dsc_data),
    .kernel_start(kernel_start), .kernel_ready(kernel_ready), .kernel_data(kernel_data),
    .complete_ready(complete_ready), .complete_accept(complete_accept),
    .complete_data(complete_data),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_data(cmpl_data),
    .cmpl_tag(cmpl_tag), .queue_level(queue_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [31:0] dd;
    logic        kr;
    logic        cr;
    logic [31:0] cd;
    logic        cmr;
    logic        e_dr;
    logic        e_ks;
    logic [31:0] e_kd;
    logic        e_ca;
    logic        e_cv;
    logic [31:0] e_cdat;
    logic [7:0]  e_tag;
    logic [2:0]  e_lvl;
    logic        e_busy;
  } vec_t;

  vec_t vec [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_kd(input string name, input logic [31:0] e);
    chk({name, ".kd_lo"}, 64'(kernel_data[31:0]), 64'(e));
    chk({name, ".kd_hi"}, 64'(kernel_data[DW-1:DW-32]), 64'(e));
  endtask

  task automatic push(input logic [31:0] d);
    dsc_valid = 1'b1;
    dsc_data  = {32{d}};
    step();
    dsc_valid = 1'b0;
  endtask

  task automatic launch_job(input logic [31:0] e);
    bit found;
    found = 1'b0;
    kernel_ready = 1'b1;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (kernel_start === 1'b1) found = 1'b1;
    end
    kernel_ready = 1'b0;
    chk("launch_seen", 64'(found), 64'd1);
    chk_kd("launch", e);
  endtask

  task automatic finish_job(input logic [31:0] cd, input logic [7:0] tag);
    bit found;
    found = 1'b0;
    complete_ready = 1'b1;
    complete_data  = cd;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (cmpl_valid === 1'b1) found = 1'b1;
    end
    chk("capture_seen", 64'(found), 64'd1);
    chk("job.cdat", 64'(cmpl_data), 64'(cd));
    chk("job.tag", 64'(cmpl_tag), 64'(tag));
    complete_ready = 1'b0;
    step();
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    chk("job.cv_clr", 64'(cmpl_valid), 64'd0);
    chk("job.idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           dv   dd            kr   cr   cd            cmr  dr   ks   kd            ca   cv   cdat          tag    lvl   busy
    vec[0]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        8'd0, 3'd1, 1'b0};
    vec[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        8'd0, 3'd0, 1'b1};
    vec[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        8'd0, 3'd0, 1'b1};
    vec[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        8'd0, 3'd0, 1'b1};
    vec[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h12345678, 8'd0, 3'd0, 1'b1};
    vec[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h12345678, 8'd0, 3'd0, 1'b1};
    vec[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1, 32'h12345678, 8'd0, 3'd0, 1'b0};
    vec[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd0, 1'b0};
    vec[8]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd1, 1'b0};
    vec[9]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd2, 1'b0};
    vec[10] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd3, 1'b0};
    vec[11] = '{1'b1, 32'h44444444, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd4, 1'b0};
    vec[12] = '{1'b1, 32'h55555555, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd4, 1'b0};
    vec[13] = '{1'b1, 32'h55555555, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd3, 1'b1};
    vec[14] = '{1'b1, 32'h55555555, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd4, 1'b1};
    vec[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h12345678, 8'd0, 3'd4, 1'b1};
    vec[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h12345678, 8'd0, 3'd4, 1'b1};
    vec[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0000BEEF, 1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b1, 32'h0000BEEF, 8'd1, 3'd4, 1'b1};
    vec[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b1, 32'h0000BEEF, 8'd1, 3'd4, 1'b0};
    vec[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h0000BEEF, 8'd1, 3'd4, 1'b0};

    reset = 1'b1; dsc_valid = 1'b0; dsc_data = '0; kernel_ready = 1'b0;
    complete_ready = 1'b0; complete_data = '0; cmpl_ready = 1'b0;
    step();
    step();
    chk("rst.dr", 64'(dsc_ready), 64'd1);
    chk("rst.ks", 64'(kernel_start), 64'd0);
    chk("rst.ca", 64'(complete_accept), 64'd0);
    chk("rst.cv", 64'(cmpl_valid), 64'd0);
    chk("rst.lvl", 64'(queue_level), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.kd_zero", 64'(kernel_data == '0), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      dsc_valid = vec[i].dv; dsc_data = {32{vec[i].dd}}; kernel_ready = vec[i].kr;
      complete_ready = vec[i].cr; complete_data = vec[i].cd; cmpl_ready = vec[i].cmr;
      step();
      chk($sformatf("v%0d.dr", i), 64'(dsc_ready), 64'(vec[i].e_dr));
      chk($sformatf("v%0d.ks", i), 64'(kernel_start), 64'(vec[i].e_ks));
      chk_kd($sformatf("v%0d", i), vec[i].e_kd);
      chk($sformatf("v%0d.ca", i), 64'(complete_accept), 64'(vec[i].e_ca));
      chk($sformatf("v%0d.cv", i), 64'(cmpl_valid), 64'(vec[i].e_cv));
      chk($sformatf("v%0d.cdat", i), 64'(cmpl_data), 64'(vec[i].e_cdat));
      chk($sformatf("v%0d.tag", i), 64'(cmpl_tag), 64'(vec[i].e_tag));
      chk($sformatf("v%0d.lvl", i), 64'(queue_level), 64'(vec[i].e_lvl));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(vec[i].e_busy));
    end
    dsc_valid = 1'b0; kernel_ready = 1'b0; complete_ready = 1'b0; cmpl_ready = 1'b0;

    // FIFO order and simultaneous push/pop at level 2
    launch_job(32'h22222222);
    finish_job(32'h00000002, 8'd2);
    launch_job(32'h33333333);
    finish_job(32'h00000003, 8'd3);
    chk("pp.lvl_before", 64'(queue_level), 64'd2);
    dsc_valid = 1'b1; dsc_data = {32{32'h66666666}}; kernel_ready = 1'b1;
    step();
    dsc_valid = 1'b0; kernel_ready = 1'b0;
    chk("pp.ks", 64'(kernel_start), 64'd1);
    chk_kd("pp", 32'h44444444);
    chk("pp.lvl_after", 64'(queue_level), 64'd2);
    finish_job(32'h00000004, 8'd4);
    launch_job(32'h55555555);
    finish_job(32'h00000005, 8'd5);
    launch_job(32'h66666666);
    finish_job(32'h00000006, 8'd6);
    chk("pp.lvl_empty", 64'(queue_level), 64'd0);

    // Reset while a job is in RUN with three descriptors still queued
    push(32'hD0D0D0D0); push(32'hD1D1D1D1); push(32'hD2D2D2D2); push(32'hD3D3D3D3);
    kernel_ready = 1'b1;
    step();
    kernel_ready = 1'b0;
    step();
    chk("mr.busy_run", 64'(busy), 64'd1);
    chk("mr.lvl_run", 64'(queue_level), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr.ks", 64'(kernel_start), 64'd0);
    chk("mr.busy", 64'(busy), 64'd0);
    chk("mr.lvl", 64'(queue_level), 64'd0);
    chk("mr.cv", 64'(cmpl_valid), 64'd0);
    chk("mr.ca", 64'(complete_accept), 64'd0);
    chk("mr.tag", 64'(cmpl_tag), 64'd0);
    chk("mr.kd_zero", 64'(kernel_data == '0), 64'd1);
    kernel_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("mr.no_start%0d", k), 64'(kernel_start), 64'd0);
      chk($sformatf("mr.idle%0d", k), 64'(busy), 64'd0);
    end
    kernel_ready = 1'b0;

    // Completion back-pressure: second capture waits for the first to be consumed
    push(32'hAAAAAAAA); push(32'hBBBBBBBB);
    launch_job(32'hAAAAAAAA);
    finish_job_hold();
    launch_job(32'hBBBBBBBB);
    complete_ready = 1'b1; complete_data = 32'hC1C1C1C1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp.ca%0d", k), 64'(complete_accept), 64'd0);
      chk($sformatf("bp.cv%0d", k), 64'(cmpl_valid), 64'd1);
      chk($sformatf("bp.cdat%0d", k), 64'(cmpl_data), 64'hC0C0C0C0);
      chk($sformatf("bp.tag%0d", k), 64'(cmpl_tag), 64'd0);
      chk($sformatf("bp.busy%0d", k), 64'(busy), 64'd1);
      step();
    end
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    chk("bp.cv_clr", 64'(cmpl_valid), 64'd0);
    chk("bp.ca_up", 64'(complete_accept), 64'd1);
    step();
    chk("bp.cv2", 64'(cmpl_valid), 64'd1);
    chk("bp.cdat2", 64'(cmpl_data), 64'hC1C1C1C1);
    chk("bp.tag2", 64'(cmpl_tag), 64'd1);
    chk("bp.ca_down", 64'(complete_accept), 64'd0);
    complete_ready = 1'b0;
    step();
    cmpl_ready = 1'b1;
    step();
    cmpl_ready = 1'b0;
    chk("bp.cv_end", 64'(cmpl_valid), 64'd0);
    chk("bp.busy_end", 64'(busy), 64'd0);

    // Tag wrap: jobs 2..256 bring the total to 257, last tags 255 then 0
    for (int j = 2; j <= 256; j++) begin
      push(32'(j));
      launch_job(32'(j));
      finish_job(32'(j) ^ 32'hF0F0F0F0, 8'(j));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // First back-pressure job: capture tag 0, release the adaptor, leave the result unconsumed
  task automatic finish_job_hold();
    bit found;
    found = 1'b0;
    complete_ready = 1'b1;
    complete_data  = 32'hC0C0C0C0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (cmpl_valid === 1'b1) found = 1'b1;
    end
    chk("bp.first_seen", 64'(found), 64'd1);
    chk("bp.first_cdat", 64'(cmpl_data), 64'hC0C0C0C0);
    chk("bp.first_tag", 64'(cmpl_tag), 64'd0);
    complete_ready = 1'b0;
    step();
    chk("bp.first_idle", 64'(busy), 64'd0);
    chk("bp.first_pending", 64'(cmpl_valid), 64'd1);
  endtask

endmodule
